// File: rtl/mem_port_arbiter_if.sv
// Line-wide memory request/response bundle, used for both requester ports and the memory port.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 26,
  parameter int DATA_W = 128
);
  logic [ADDR_W-1:0] addr;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              readdata_valid;
  logic              waitrequest;

  modport master (
    output addr, read, write, writedata,
    input  readdata, readdata_valid, waitrequest
  );

  modport slave (
    input  addr, read, write, writedata,
    output readdata, readdata_valid, waitrequest
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for the shared line-wide memory port (port 0 = I-cache, port 1 = D-cache).
// state | meaning
// IDLE  | no transaction; arbitrate and latch the winning command
// CMD   | command driven to memory until accepted
// RESP  | read accepted; waiting for read data
module mem_port_arbiter #(
  parameter int ADDR_W = 26,
  parameter int DATA_W = 128,
  parameter int CNT_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  p0,
  mem_port_arbiter_if.slave  p1,
  mem_port_arbiter_if.master m,
  output logic               busy,
  output logic [CNT_W-1:0]   cnt_grant0,
  output logic [CNT_W-1:0]   cnt_grant1
);

  typedef enum logic [1:0] {IDLE, CMD, RESP} state_t;

  state_t            state;
  logic              last_grant;
  logic              grant;
  logic              kind_wr;
  logic              req0;
  logic              req1;
  logic              pick;
  logic              sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              rd_done;
  logic              wr_done;
  logic              done;

  assign req0      = p0.read | p0.write;
  assign req1      = p1.read | p1.write;
  assign pick      = (req0 & req1) ? ~last_grant : req1;
  assign sel_wr    = pick ? p1.write     : p0.write;
  assign sel_addr  = pick ? p1.addr      : p0.addr;
  assign sel_wdata = pick ? p1.writedata : p0.writedata;

  // Completion is suppressed during reset so an abandoned transaction never reports.
  assign rd_done = ~rst & ~kind_wr & m.readdata_valid &
                   ((state == RESP) | ((state == CMD) & ~m.waitrequest));
  assign wr_done = ~rst & kind_wr & (state == CMD) & ~m.waitrequest;
  assign done    = rd_done | wr_done;

  assign p0.readdata       = m.readdata;
  assign p1.readdata       = m.readdata;
  assign p0.readdata_valid = rd_done & ~grant;
  assign p1.readdata_valid = rd_done & grant;
  assign p0.waitrequest    = req0 & ~(done & ~grant);
  assign p1.waitrequest    = req1 & ~(done & grant);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      m.read      <= 1'b0;
      m.write     <= 1'b0;
      m.addr      <= '0;
      m.writedata <= '0;
      cnt_grant0  <= '0;
      cnt_grant1  <= '0;
      last_grant  <= 1'b1;
      grant       <= 1'b0;
      kind_wr     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            grant       <= pick;
            last_grant  <= pick;
            kind_wr     <= sel_wr;
            m.addr      <= sel_addr;
            m.writedata <= sel_wdata;
            m.read      <= ~sel_wr;
            m.write     <= sel_wr;
            busy        <= 1'b1;
            state       <= CMD;
            if (pick) cnt_grant1 <= cnt_grant1 + CNT_W'(1);
            else      cnt_grant0 <= cnt_grant0 + CNT_W'(1);
          end
        end
        CMD: begin
          if (!m.waitrequest) begin
            m.read  <= 1'b0;
            m.write <= 1'b0;
            if (kind_wr || m.readdata_valid) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              state <= RESP;
            end
          end
        end
        RESP: begin
          if (m.readdata_valid) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy    <= 1'b0;
          m.read  <= 1'b0;
          m.write <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
